// File: rtl/add_sub_pkg.sv
// Shared constants and helpers for the pipelined add/subtract unit.
//   FUNC_ADD / FUNC_SUB : encodings of the func input.
//   sat_fill()          : the saturation constant, returned as an MSB value
//                         plus the value repeated in every lower bit. Callers
//                         expand it to their own WIDTH.
package add_sub_pkg;

  localparam logic FUNC_ADD = 1'b0;
  localparam logic FUNC_SUB = 1'b1;

  typedef struct packed {
    logic msb;
    logic rest;
  } sat_fill_t;

  // signed   : negative overflow -> 100..0, positive overflow -> 011..1
  // unsigned : add overflow -> all ones, sub underflow -> all zeros
  function automatic sat_fill_t sat_fill(input logic sign, input logic func,
                                         input logic neg);
    sat_fill_t f;
    f = '0;
    if (sign) begin
      f.msb  = neg;
      f.rest = ~neg;
    end else if (func == FUNC_ADD) begin
      f.msb  = 1'b1;
      f.rest = 1'b1;
    end
    return f;
  endfunction

endpackage

// File: rtl/add_sub_pipe_if.sv
// Handshake bus of add_sub_pipe.
//   Request : in_valid/in_ready, A, B, func, Sign, Sat, tag_in
//   Response: out_valid/out_ready, S, Z, V, N, tag_out
//   slave  = the add/sub unit's view, master = the producer/consumer view.
interface add_sub_pipe_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             func;
  logic             Sign;
  logic             Sat;
  logic [TAG_W-1:0] tag_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] S;
  logic             Z;
  logic             V;
  logic             N;
  logic [TAG_W-1:0] tag_out;

  modport slave (
    input  in_valid, A, B, func, Sign, Sat, tag_in, out_ready,
    output in_ready, out_valid, S, Z, V, N, tag_out
  );

  modport master (
    output in_valid, A, B, func, Sign, Sat, tag_in, out_ready,
    input  in_ready, out_valid, S, Z, V, N, tag_out
  );
endinterface

// File: rtl/add_sub_group.sv
// Combinational GROUP-bit carry-lookahead adder slice.
//   a, b : operand slices (b already inverted for subtraction)
//   cin  : carry into bit 0
//   s    : sum slice
//   cout : carry out of the top bit
//   ctop : carry into the top bit (used for signed overflow)
module add_sub_group #(
  parameter int unsigned GROUP = 8
) (
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             cin,
  output logic [GROUP-1:0] s,
  output logic             cout,
  output logic             ctop
);

  logic [GROUP-1:0] p;
  logic [GROUP-1:0] g;
  logic [GROUP:0]   c;
  logic             acc;
  logic             prod;

  assign p = a ^ b;
  assign g = a & b;

  // Each carry is the flat sum-of-products over generate/propagate terms,
  // so no carry depends on a lower carry.
  always_comb begin
    c    = '0;
    acc  = 1'b0;
    prod = 1'b0;
    c[0] = cin;
    for (int unsigned i = 0; i < GROUP; i++) begin
      acc  = g[i];
      prod = p[i];
      for (int unsigned j = i; j > 0; j--) begin
        acc  = acc | (prod & g[j-1]);
        prod = prod & p[j-1];
      end
      c[i+1] = acc | (prod & cin);
    end
  end

  assign s    = p ^ c[GROUP-1:0];
  assign cout = c[GROUP];
  assign ctop = c[GROUP-1];

endmodule

// File: rtl/add_sub_pipe.sv
// Pipelined add/subtract unit, WIDTH/GROUP stages, one op per clock.
//   clk, rst : clock, synchronous active-high reset
//   bus      : add_sub_pipe_if.slave (request/response handshake, operands,
//              func/Sign/Sat controls, tag, result S with Z/V/N flags)
// Stage k resolves bits [k*GROUP +: GROUP] using the carry registered by
// stage k-1; the whole pipeline stalls together when the output is held.
module add_sub_pipe #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned GROUP = 8,
  parameter int unsigned TAG_W = 4
) (
  input  logic           clk,
  input  logic           rst,
  add_sub_pipe_if.slave  bus
);
  import add_sub_pkg::*;

  localparam int unsigned NST = WIDTH / GROUP;

  typedef struct packed {
    logic             v;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] s;
    logic             c;
    logic             cmsb;
    logic             func;
    logic             sign;
    logic             sat;
    logic [TAG_W-1:0] tag;
  } stage_t;

  stage_t           in_st;
  stage_t           src   [NST];
  stage_t           res   [NST];
  stage_t           pq    [NST];
  logic [GROUP-1:0] gsum  [NST];
  logic             gcout [NST];
  logic             gtop  [NST];
  logic             adv;

  assign adv          = ~pq[NST-1].v | bus.out_ready;
  assign bus.in_ready = adv;

  always_comb begin
    in_st      = '0;
    in_st.v    = bus.in_valid;
    in_st.a    = bus.A;
    in_st.b    = (bus.func == FUNC_SUB) ? ~bus.B : bus.B;
    in_st.c    = bus.func;
    in_st.func = bus.func;
    in_st.sign = bus.Sign;
    in_st.sat  = bus.Sat;
    in_st.tag  = bus.tag_in;
  end

  always_comb begin
    src[0] = in_st;
    for (int unsigned k = 1; k < NST; k++) begin
      src[k] = pq[k-1];
    end
  end

  for (genvar k = 0; k < NST; k++) begin : g_grp
    add_sub_group #(.GROUP(GROUP)) u_grp (
      .a    (src[k].a[k*GROUP +: GROUP]),
      .b    (src[k].b[k*GROUP +: GROUP]),
      .cin  (src[k].c),
      .s    (gsum[k]),
      .cout (gcout[k]),
      .ctop (gtop[k])
    );
  end

  always_comb begin
    for (int unsigned k = 0; k < NST; k++) begin
      res[k]                       = src[k];
      res[k].s[k*GROUP +: GROUP]   = gsum[k];
      res[k].c                     = gcout[k];
      res[k].cmsb                  = gtop[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < NST; k++) begin
        pq[k] <= '0;
      end
    end else if (adv) begin
      for (int unsigned k = 0; k < NST; k++) begin
        pq[k] <= res[k];
      end
    end
  end

  // Final-stage flags and saturation. Outputs are forced to zero while no
  // result is held so the reset state reads S=0 and Z=V=N=0.
  logic             v_f;
  logic             n_f;
  sat_fill_t        fill;
  logic [WIDTH-1:0] sat_val;
  logic [WIDTH-1:0] s_sel;

  always_comb begin
    v_f     = pq[NST-1].sign ? (pq[NST-1].cmsb ^ pq[NST-1].c)
                             : (pq[NST-1].c ^ pq[NST-1].func);
    n_f     = pq[NST-1].sign ? (v_f ^ pq[NST-1].s[WIDTH-1])
                             : (pq[NST-1].func & v_f);
    fill    = sat_fill(pq[NST-1].sign, pq[NST-1].func, n_f);
    sat_val = {fill.msb, {(WIDTH-1){fill.rest}}};
    s_sel   = (pq[NST-1].sat & v_f) ? sat_val : pq[NST-1].s;
  end

  assign bus.out_valid = pq[NST-1].v;
  assign bus.S         = pq[NST-1].v ? s_sel : '0;
  assign bus.Z         = pq[NST-1].v & (s_sel == '0);
  assign bus.V         = pq[NST-1].v & v_f;
  assign bus.N         = pq[NST-1].v & n_f;
  assign bus.tag_out   = pq[NST-1].v ? pq[NST-1].tag : '0;

endmodule

// File: tb/tb_add_sub_pipe.sv
module tb_add_sub_pipe;
  import add_sub_pkg::*;

  localparam int unsigned W   = 32;
  localparam int unsigned G   = 8;
  localparam int unsigned T   = 4;
  localparam int          NST = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  add_sub_pipe_if #(.WIDTH(W), .TAG_W(T)) bus ();

  add_sub_pipe #(.WIDTH(W), .GROUP(G), .TAG_W(T)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        func;
    logic        sign;
    logic        sat;
    logic [31:0] s;
    logic        z;
    logic        v;
    logic        n;
  } vec_t;

  typedef struct {
    logic [31:0] s;
    logic        z;
    logic        v;
    logic        n;
    logic [3:0]  tag;
    int          acc_cyc;
  } exp_t;

  vec_t vecs [16];
  exp_t sbq  [$];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  bit nostall    = 1'b1;
  bit rand_ready = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h required 0x%08h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic set_v(input int i, input logic [31:0] a, input logic [31:0] b,
                       input logic f, input logic sg, input logic st,
                       input logic [31:0] s, input logic z, input logic v, input logic n);
    vecs[i].a = a; vecs[i].b = b; vecs[i].func = f; vecs[i].sign = sg; vecs[i].sat = st;
    vecs[i].s = s; vecs[i].z = z; vecs[i].v = v; vecs[i].n = n;
  endtask

  task automatic drive_fields(input int idx, input logic [3:0] tag);
    bus.in_valid = 1'b1;
    bus.A        = vecs[idx].a;
    bus.B        = vecs[idx].b;
    bus.func     = vecs[idx].func;
    bus.Sign     = vecs[idx].sign;
    bus.Sat      = vecs[idx].sat;
    bus.tag_in   = tag;
  endtask

  // Called just after a rising edge with the request driven; returns just
  // after the rising edge on which it was accepted.
  task automatic wait_accept(input int idx, input logic [3:0] tag);
    exp_t e;
    int   tries;
    tries = 0;
    forever begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) begin
        e.s = vecs[idx].s; e.z = vecs[idx].z; e.v = vecs[idx].v; e.n = vecs[idx].n;
        e.tag = tag; e.acc_cyc = cyc;
        sbq.push_back(e);
        @(posedge clk); #1;
        break;
      end
      tries++;
      if (tries > 200) begin
        checks++; errors++;
        $display("FAIL accept_timeout: tag %0d not accepted, required accept within 200 cycles", tag);
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic issue(input int idx, input logic [3:0] tag);
    drive_fields(idx, tag);
    wait_accept(idx, tag);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    check("drain_queue_empty", 32'(sbq.size()), 32'd0);
    repeat (6) @(posedge clk);
    #1;
  endtask

  // out_ready driver
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      bus.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor / scoreboard
  initial begin
    bit          prev_stall;
    logic [31:0] h_s;
    logic [3:0]  h_tag;
    logic        h_z, h_v, h_n;
    exp_t        e;
    prev_stall = 1'b0;
    forever begin
      @(negedge clk);
      if (rst !== 1'b0) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall && bus.out_valid === 1'b1) begin
          check("hold_S",   bus.S, h_s);
          check("hold_tag", 32'(bus.tag_out), 32'(h_tag));
          check("hold_ZVN", 32'({bus.Z, bus.V, bus.N}), 32'({h_z, h_v, h_n}));
        end
        if (bus.out_valid === 1'b1)
          check("in_ready_eq_out_ready", 32'(bus.in_ready), 32'(bus.out_ready));
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
          if (sbq.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_output: got tag %0d S=0x%08h, required no output",
                     bus.tag_out, bus.S);
          end else begin
            e = sbq.pop_front();
            check("S",   bus.S, e.s);
            check("Z",   32'(bus.Z), 32'(e.z));
            check("V",   32'(bus.V), 32'(e.v));
            check("N",   32'(bus.N), 32'(e.n));
            check("tag", 32'(bus.tag_out), 32'(e.tag));
            if (nostall) check("latency", 32'(cyc - e.acc_cyc), 32'(NST));
          end
        end
        prev_stall = (bus.out_valid === 1'b1) && (bus.out_ready === 1'b0);
        h_s = bus.S; h_tag = bus.tag_out; h_z = bus.Z; h_v = bus.V; h_n = bus.N;
      end
    end
  end

  initial begin
    //     idx  A             B             func      sign sat  S             Z  V  N
    set_v( 0, 32'h7FFFFFFF, 32'h00000001, FUNC_ADD, 1, 0, 32'h80000000, 0, 1, 0);
    set_v( 1, 32'h7FFFFFFF, 32'h00000001, FUNC_ADD, 1, 1, 32'h7FFFFFFF, 0, 1, 0);
    set_v( 2, 32'h00000003, 32'h00000005, FUNC_SUB, 0, 0, 32'hFFFFFFFE, 0, 1, 1);
    set_v( 3, 32'h00000003, 32'h00000005, FUNC_SUB, 0, 1, 32'h00000000, 1, 1, 1);
    set_v( 4, 32'h12345678, 32'h12345678, FUNC_SUB, 1, 0, 32'h00000000, 1, 0, 0);
    set_v( 5, 32'h12345678, 32'h12345678, FUNC_SUB, 0, 0, 32'h00000000, 1, 0, 0);
    set_v( 6, 32'hFFFFFFFF, 32'h00000001, FUNC_ADD, 0, 0, 32'h00000000, 1, 1, 0);
    set_v( 7, 32'hFFFFFFFF, 32'h00000001, FUNC_ADD, 0, 1, 32'hFFFFFFFF, 0, 1, 0);
    set_v( 8, 32'h80000000, 32'hFFFFFFFF, FUNC_ADD, 1, 1, 32'h80000000, 0, 1, 1);
    set_v( 9, 32'h00000005, 32'hFFFFFFFD, FUNC_ADD, 1, 0, 32'h00000002, 0, 0, 0);
    set_v(10, 32'h00000002, 32'h00000007, FUNC_SUB, 1, 1, 32'hFFFFFFFB, 0, 0, 1);
    set_v(11, 32'h0000FFFF, 32'h00000001, FUNC_ADD, 0, 0, 32'h00010000, 0, 0, 0);
    set_v(12, 32'h00010000, 32'h00000001, FUNC_SUB, 0, 0, 32'h0000FFFF, 0, 0, 0);
    set_v(13, 32'h80000000, 32'h00000001, FUNC_SUB, 1, 1, 32'h80000000, 0, 1, 1);
    set_v(14, 32'h80000000, 32'h80000000, FUNC_ADD, 0, 0, 32'h00000000, 1, 1, 0);
    set_v(15, 32'h00FF00FF, 32'h01010101, FUNC_ADD, 1, 0, 32'h02000200, 0, 0, 0);

    rst = 1'b1;
    bus.in_valid = 1'b0; bus.A = '0; bus.B = '0; bus.func = 1'b0;
    bus.Sign = 1'b0; bus.Sat = 1'b0; bus.tag_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_S",         bus.S, 32'd0);
    check("rst_ZVN",       32'({bus.Z, bus.V, bus.N}), 32'd0);
    check("rst_tag_out",   32'(bus.tag_out), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Back-to-back stream, consumer always ready
    for (int i = 0; i < 16; i++) issue(i, 4'(i));
    bus.in_valid = 1'b0;
    drain();

    // Same stream with a stalling consumer
    nostall = 1'b0; rand_ready = 1'b1;
    for (int i = 0; i < 16; i++) issue(i, 4'(i));
    bus.in_valid = 1'b0;
    drain();
    rand_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    nostall = 1'b1;

    // Three ops in flight, then a one-cycle reset discards them
    drive_fields(0, 4'd10); @(posedge clk); #1;
    drive_fields(2, 4'd11); @(posedge clk); #1;
    drive_fields(8, 4'd12); @(posedge clk); #1;
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    drive_fields(9, 4'd13);
    #1;
    check("post_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("post_rst_S",         bus.S, 32'd0);
    check("post_rst_in_ready",  32'(bus.in_ready), 32'd1);
    wait_accept(9, 4'd13);
    bus.in_valid = 1'b0;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
